// File: rtl/hazard_scoreboard.sv
// Issue-stage hazard scoreboard: tracks in-flight long-latency writes and
// stalls D on RAW/WAW hazards or when all outstanding slots are in use.
module hazard_scoreboard #(
  parameter  int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned CW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dec_valid,
  input  logic [31:0]   dec_instr,
  input  logic          dec_uses_rs2,
  input  logic          dec_regwrite,
  input  logic          dec_long,
  input  logic          flush,
  input  logic          wb_valid,
  input  logic [4:0]    wb_rd,
  output logic          stall,
  output logic [31:0]   pending,
  output logic [CW-1:0] outstanding,
  output logic          wb_err
);

  localparam int unsigned NREG = 32;

  logic [NREG-1:0] r_pending;
  logic [CW-1:0]   r_outstanding;
  logic            r_wb_err;

  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd;
  logic            w_tracked;
  logic            w_wb_hit;
  logic [NREG-1:0] w_clr_mask;
  logic [NREG-1:0] w_set_mask;
  logic [NREG-1:0] w_eff_pending;
  logic            w_raw1;
  logic            w_raw2;
  logic            w_waw;
  logic            w_struct;
  logic            w_accept;
  logic            w_set;
  logic [NREG-1:0] w_pending_nxt;
  logic [CW-1:0]   w_outstanding_nxt;
  logic            w_unused_instr;

  assign w_rs1 = dec_instr[19:15];
  assign w_rs2 = dec_instr[24:20];
  assign w_rd  = dec_instr[11:7];
  assign w_unused_instr = ^{dec_instr[31:25], dec_instr[14:12], dec_instr[6:0]};

  // Hazard detection against pending bits with same-cycle writebacks already retired
  always_comb begin
    w_tracked     = 1'b0;
    w_wb_hit      = 1'b0;
    w_clr_mask    = '0;
    w_set_mask    = '0;
    w_eff_pending = r_pending;
    w_raw1        = 1'b0;
    w_raw2        = 1'b0;
    w_waw         = 1'b0;
    w_struct      = 1'b0;
    stall         = 1'b0;
    w_accept      = 1'b0;
    w_set         = 1'b0;

    w_tracked = dec_regwrite & dec_long & (w_rd != 5'd0);
    w_wb_hit  = wb_valid & r_pending[wb_rd] & (wb_rd != 5'd0);
    if (w_wb_hit) w_clr_mask = NREG'(1) << wb_rd;
    w_eff_pending = r_pending & ~w_clr_mask;

    w_raw1   = dec_valid & (w_rs1 != 5'd0) & w_eff_pending[w_rs1];
    w_raw2   = dec_valid & dec_uses_rs2 & (w_rs2 != 5'd0) & w_eff_pending[w_rs2];
    w_waw    = dec_valid & dec_regwrite & (w_rd != 5'd0) & w_eff_pending[w_rd];
    w_struct = dec_valid & w_tracked &
               (CW'(r_outstanding - CW'(w_wb_hit)) == CW'(MAX_OUTSTANDING));

    stall    = ~flush & (w_raw1 | w_raw2 | w_waw | w_struct);
    w_accept = dec_valid & ~stall & ~flush;
    w_set    = w_accept & w_tracked;
    if (w_set) w_set_mask = NREG'(1) << w_rd;
  end

  // Set applied after clear so a same-register set/clear leaves the bit high
  assign w_pending_nxt     = (r_pending & ~w_clr_mask) | w_set_mask;
  assign w_outstanding_nxt = CW'(r_outstanding + CW'(w_set) - CW'(w_wb_hit));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending     <= '0;
      r_outstanding <= '0;
      r_wb_err      <= 1'b0;
    end else begin
      r_pending     <= w_pending_nxt;
      r_outstanding <= w_outstanding_nxt;
      if (wb_valid && !w_wb_hit) r_wb_err <= 1'b1;
    end
  end

  assign pending     = r_pending;
  assign outstanding = r_outstanding;
  assign wb_err      = r_wb_err;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: the driver queues the expected per-cycle outputs, and a
// negedge monitor pops and compares them against the DUT.
module tb_hazard_scoreboard;

  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          dec_valid;
  logic [31:0]   dec_instr;
  logic          dec_uses_rs2;
  logic          dec_regwrite;
  logic          dec_long;
  logic          flush;
  logic          wb_valid;
  logic [4:0]    wb_rd;
  logic          stall;
  logic [31:0]   pending;
  logic [CW-1:0] outstanding;
  logic          wb_err;

  typedef struct {
    int            id;
    logic          stall;
    logic [31:0]   pend;
    logic [CW-1:0] outs;
    logic          err;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   vid = 0;

  hazard_scoreboard #(.MAX_OUTSTANDING(4)) dut (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_instr(dec_instr),
    .dec_uses_rs2(dec_uses_rs2), .dec_regwrite(dec_regwrite), .dec_long(dec_long),
    .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd), .stall(stall),
    .pending(pending), .outstanding(outstanding), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  // Monitor: outputs are stable at the falling edge
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks += 4;
      if (stall !== e.stall) begin
        n_errors++;
        $display("FAIL stall vec%0d: got %b want %b", e.id, stall, e.stall);
      end
      if (pending !== e.pend) begin
        n_errors++;
        $display("FAIL pending vec%0d: got %h want %h", e.id, pending, e.pend);
      end
      if (outstanding !== e.outs) begin
        n_errors++;
        $display("FAIL outstanding vec%0d: got %0d want %0d", e.id, outstanding, e.outs);
      end
      if (wb_err !== e.err) begin
        n_errors++;
        $display("FAIL wb_err vec%0d: got %b want %b", e.id, wb_err, e.err);
      end
    end
  end

  task automatic drive(input logic dv, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic u2, input logic rw,
                       input logic lg, input logic fl, input logic wv,
                       input logic [4:0] wrd);
    dec_valid    = dv;
    dec_instr    = {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
    dec_uses_rs2 = u2;
    dec_regwrite = rw;
    dec_long     = lg;
    flush        = fl;
    wb_valid     = wv;
    wb_rd        = wrd;
  endtask

  task automatic expect_now(input logic es, input logic [31:0] ep,
                            input logic [CW-1:0] eo, input logic ee);
    q.push_back('{vid, es, ep, eo, ee});
    vid++;
  endtask

  // One cycle: drive inputs, queue the outputs expected during this cycle
  task automatic cyc(input logic dv, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic u2, input logic rw,
                     input logic lg, input logic fl, input logic wv,
                     input logic [4:0] wrd, input logic es, input logic [31:0] ep,
                     input logic [CW-1:0] eo, input logic ee);
    @(posedge clk);
    #1;
    drive(dv, rs1, rs2, rd, u2, rw, lg, fl, wv, wrd);
    expect_now(es, ep, eo, ee);
  endtask

  task automatic idle(input logic [31:0] ep, input logic [CW-1:0] eo, input logic ee);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, ep, eo, ee);
  endtask

  task automatic wb(input logic [4:0] wrd, input logic [31:0] ep,
                    input logic [CW-1:0] eo, input logic ee);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, wrd, 1'b0, ep, eo, ee);
  endtask

  task automatic ld(input logic [4:0] rd, input logic es, input logic [31:0] ep,
                    input logic [CW-1:0] eo);
    cyc(1, 0, 0, rd, 0, 1, 1, 0, 0, 0, es, ep, eo, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    idle(32'h0, 0, 0);
    // Load x5, then dependent add stalls until the writeback cycle
    ld(5, 0, 32'h0, 0);
    cyc(1, 5, 0, 6, 0, 1, 0, 0, 0, 0, 1, 32'h20, 1, 0);
    cyc(1, 5, 0, 6, 0, 1, 0, 0, 0, 0, 1, 32'h20, 1, 0);
    cyc(1, 5, 0, 6, 0, 1, 0, 0, 1, 5, 0, 32'h20, 1, 0);
    idle(32'h0, 0, 0);
    // Untracked: rd=0 long op, flushed long op
    ld(0, 0, 32'h0, 0);
    cyc(1, 0, 0, 3, 0, 1, 1, 1, 0, 0, 0, 32'h0, 0, 0);
    idle(32'h0, 0, 0);
    // Fill all four slots, fifth stalls until a writeback frees one
    ld(1, 0, 32'h00, 0);
    ld(2, 0, 32'h02, 1);
    ld(3, 0, 32'h06, 2);
    ld(4, 0, 32'h0E, 3);
    ld(6, 1, 32'h1E, 4);
    cyc(1, 0, 0, 6, 0, 1, 1, 0, 1, 2, 0, 32'h1E, 4, 0);
    idle(32'h5A, 4, 0);
    // Flush masks a RAW; rs2 only counts when used; WAW on short op
    cyc(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h5A, 4, 0);
    cyc(1, 0, 3, 8, 1, 1, 0, 0, 0, 0, 1, 32'h5A, 4, 0);
    cyc(1, 0, 3, 8, 0, 1, 0, 0, 0, 0, 0, 32'h5A, 4, 0);
    cyc(1, 0, 0, 4, 0, 1, 0, 0, 0, 0, 1, 32'h5A, 4, 0);
    wb(1, 32'h5A, 4, 0);
    wb(3, 32'h58, 3, 0);
    wb(4, 32'h50, 2, 0);
    wb(6, 32'h40, 1, 0);
    // Same-cycle writeback and reissue to x7
    ld(7, 0, 32'h00, 0);
    idle(32'h80, 1, 0);
    cyc(1, 0, 0, 7, 0, 1, 1, 0, 1, 7, 0, 32'h80, 1, 0);
    idle(32'h80, 1, 0);
    // Spurious writeback is sticky
    wb(9, 32'h80, 1, 0);
    idle(32'h80, 1, 1);
    idle(32'h80, 1, 1);
    // Asynchronous reset between edges
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    expect_now(1'b0, 32'h0, 0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    // Writeback for a discarded op flags an error
    wb(7, 32'h0, 0, 0);
    idle(32'h0, 0, 1);
    wb(0, 32'h0, 0, 1);
    idle(32'h0, 0, 1);

    repeat (2) @(posedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL queue_drain: got %0d entries want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter: MAX_OUTSTANDING, default 4, maximum number of in-flight long-latency writes (legal range 1..31).
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: dec_valid  input  1  instruction in D stage is valid and requesting issue to EX.
REQ-005 Port: dec_instr  input  32  D-stage instruction; rs1=[19:15], rs2=[24:20], rd=[11:7].
REQ-006 Port: dec_uses_rs2  input  1  D-stage instruction reads rs2.
REQ-007 Port: dec_regwrite  input  1  D-stage instruction writes rd.
REQ-008 Port: dec_long  input  1  D-stage instruction is long-latency (load/mul/div); its result is not forwardable from EX/MEM.
REQ-009 Port: flush  input  1  D-stage instruction is squashed this cycle.
REQ-010 Port: wb_valid  input  1  a long-latency result is written back this cycle.
REQ-011 Port: wb_rd  input  5  destination register of that writeback.
REQ-012 Port: stall  output  1  hold D stage this cycle.
REQ-013 Port: pending  output  32  registered pending-write bit per register; bit 0 always 0.
REQ-014 Port: outstanding  output  clog2(MAX_OUTSTANDING+1)  registered count of set pending bits.
REQ-015 Port: wb_err  output  1  sticky error: writeback to a non-pending register.

Function
REQ-016 tracked = dec_regwrite & dec_long & (rd != 0).
REQ-017 wb_hit = wb_valid & pending[wb_rd] & (wb_rd != 0).
REQ-018 eff_pending = pending with bit wb_rd cleared when wb_hit (same-cycle writeback resolves the hazard; register file is write-before-read).
REQ-019 RAW hazard: dec_valid & rs1 != 0 & eff_pending[rs1].
REQ-020 RAW hazard: dec_valid & dec_uses_rs2 & rs2 != 0 & eff_pending[rs2].
REQ-021 WAW hazard: dec_valid & dec_regwrite & rd != 0 & eff_pending[rd].
REQ-022 Structural hazard: dec_valid & tracked & (outstanding - wb_hit) == MAX_OUTSTANDING.
REQ-023 stall is combinational: OR of REQ-019..022, forced 0 when flush=1.
REQ-024 accept = dec_valid & ~stall & ~flush.
REQ-025 Next edge: pending[rd] set when accept & tracked; pending[wb_rd] cleared when wb_hit.
REQ-026 Same register set and cleared in one cycle: set wins, bit stays 1, count unchanged.
REQ-027 outstanding next = outstanding + (accept & tracked) - wb_hit; never wraps; always equals popcount(pending).
REQ-028 wb_valid with wb_rd not pending, or wb_rd = 0: no state change except wb_err <= 1.
REQ-029 Untracked instructions (short, non-writing, or rd = 0) never set bits or change the count.
REQ-030 Latency: a set bit is visible to stall on the cycle after accept; a clear is visible in the same cycle (REQ-018).

Reset
REQ-031 rst_n low asynchronously clears pending, outstanding, and wb_err to 0 regardless of the clock.
REQ-032 Reset mid-operation discards all in-flight tracking; later writebacks for discarded ops set wb_err.
REQ-033 After reset with dec_valid = 0, stall = 0.

Verification
REQ-034 Load x5 accepted (dec_long=1, rd=5) -> pending=0x20, outstanding=1 next cycle; then add rs1=5 -> stall=1 until the wb_rd=5 cycle, when stall=0 in that same cycle.
REQ-035 MAX_OUTSTANDING=4; issue long ops to x1..x4 -> outstanding=4; fifth long op to x6 -> stall=1; in the cycle wb_rd=2 arrives -> stall=0, x6 accepted, outstanding stays 4, pending=0x5A.
REQ-036 Long op with rd=0 or with flush=1 -> pending and outstanding unchanged, stall=0.
REQ-037 Pending x7; in one cycle wb_rd=7 and a long op writing x7 is issued -> accepted (no WAW), pending[7]=1, outstanding unchanged.
REQ-038 wb_valid with wb_rd=9 not pending -> wb_err=1 and stays 1; pending and outstanding unchanged; rst_n pulsed low between clock edges -> all outputs 0 immediately.
